// File: rtl/instruction_fetch.sv
// Instruction fetch front end: program store, PC sequencing and a registered instruction bus to decode.
// Optional IF_PERF_CNT_EN adds saturating issue/stall counters as extra outputs.
module instruction_fetch #(
    parameter int unsigned PC_WIDTH    = 4,
    parameter logic [2:0]  HALT_OPCODE = 3'b111
) (
    input  logic                sysclk,
    input  logic                reset,
    input  logic                load_en,
    input  logic [PC_WIDTH-1:0] load_addr,
    input  logic [7:0]          load_data,
    input  logic                start,
    input  logic                inst_ready,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic                inst_valid,
    output logic [2:0]          inst,
    output logic                rs,
    output logic                rt,
    output logic [2:0]          imm,
    output logic [PC_WIDTH-1:0] inst_pc,
    output logic                halted,
    output logic                busy
`ifdef IF_PERF_CNT_EN
    ,
    output logic [15:0]         issue_count,
    output logic [15:0]         stall_count
`endif
);

    localparam int unsigned DEPTH = 2 ** PC_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_pc_next;
    logic [7:0]          r_mem [DEPTH];
    logic [7:0]          w_word;
    logic                w_is_halt;
    logic                w_handshake;
    logic                w_load;
    logic                w_valid_next;

    logic                r_inst_valid;
    logic [2:0]          r_inst;
    logic                r_rs;
    logic                r_rt;
    logic [2:0]          r_imm;
    logic [PC_WIDTH-1:0] r_inst_pc;
    logic                r_halted;
    logic                r_busy;

    // Asynchronous read; a write this cycle lands at the edge, so readers see the old word
    assign w_word      = r_mem[r_pc];
    assign w_is_halt   = (w_word[7:5] == HALT_OPCODE);
    assign w_handshake = r_inst_valid & inst_ready;

    always_ff @(posedge sysclk) begin
        if (load_en && !reset) begin
            r_mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    // Next state; a branch outranks halt detection and the issue path
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_valid_next = r_inst_valid;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE, S_HALT: begin
                w_valid_next = 1'b0;
                if (start) begin
                    w_state_next = S_FETCH;
                    w_pc_next    = '0;
                end
            end
            S_FETCH: begin
                if (branch_taken) begin
                    w_valid_next = 1'b0;
                    w_pc_next    = branch_target;
                end else if (w_is_halt) begin
                    w_valid_next = 1'b0;
                    w_state_next = S_HALT;
                end else begin
                    w_load       = 1'b1;
                    w_valid_next = 1'b1;
                    w_pc_next    = r_pc + PC_WIDTH'(1);
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (branch_taken) begin
                    w_valid_next = 1'b0;
                    w_pc_next    = branch_target;
                    w_state_next = S_FETCH;
                end else if (w_handshake) begin
                    if (w_is_halt) begin
                        w_valid_next = 1'b0;
                        w_state_next = S_HALT;
                    end else begin
                        w_load       = 1'b1;
                        w_valid_next = 1'b1;
                        w_pc_next    = r_pc + PC_WIDTH'(1);
                    end
                end
            end
            default: begin
                w_valid_next = 1'b0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_inst_valid <= 1'b0;
            r_inst       <= '0;
            r_rs         <= 1'b0;
            r_rt         <= 1'b0;
            r_imm        <= '0;
            r_inst_pc    <= '0;
            r_halted     <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_inst_valid <= w_valid_next;
            if (w_load) begin
                r_inst    <= w_word[7:5];
                r_rs      <= w_word[4];
                r_rt      <= w_word[3];
                r_imm     <= w_word[2:0];
                r_inst_pc <= r_pc;
            end
            r_halted <= (w_state_next == S_HALT);
            r_busy   <= (w_state_next == S_FETCH) || (w_state_next == S_ISSUE);
        end
    end

    assign inst_valid = r_inst_valid;
    assign inst       = r_inst;
    assign rs         = r_rs;
    assign rt         = r_rt;
    assign imm        = r_imm;
    assign inst_pc    = r_inst_pc;
    assign halted     = r_halted;
    assign busy       = r_busy;

`ifdef IF_PERF_CNT_EN
    logic [15:0] r_issue_count;
    logic [15:0] r_stall_count;
    logic        w_start_accept;

    assign w_start_accept = start && ((r_state == S_IDLE) || (r_state == S_HALT));

    // Saturating counters, cleared whenever a run is (re)started
    always_ff @(posedge sysclk) begin
        if (reset || w_start_accept) begin
            r_issue_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_handshake && (r_issue_count != 16'hFFFF)) begin
                r_issue_count <= r_issue_count + 16'd1;
            end
            if (r_inst_valid && !inst_ready && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign issue_count = r_issue_count;
    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a randomized run against
// a program-order model (expected issue stream = mem[pc], mem[pc+1], ... until a HALT word).
module tb_instruction_fetch;

    logic       sysclk = 1'b0;
    logic       reset = 1'b0;
    logic       load_en = 1'b0;
    logic [3:0] load_addr = '0;
    logic [7:0] load_data = '0;
    logic       start = 1'b0;
    logic       inst_ready = 1'b0;
    logic       branch_taken = 1'b0;
    logic [3:0] branch_target = '0;
    logic       inst_valid;
    logic [2:0] inst;
    logic       rs;
    logic       rt;
    logic [2:0] imm;
    logic [3:0] inst_pc;
    logic       halted;
    logic       busy;
`ifdef IF_PERF_CNT_EN
    logic [15:0] issue_count;
    logic [15:0] stall_count;
`endif

    int checks = 0;
    int failures = 0;
    logic [7:0] mem_model [16];

    instruction_fetch dut (
        .sysclk        (sysclk),
        .reset         (reset),
        .load_en       (load_en),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .start         (start),
        .inst_ready    (inst_ready),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .rs            (rs),
        .rt            (rt),
        .imm           (imm),
        .inst_pc       (inst_pc),
        .halted        (halted),
        .busy          (busy)
`ifdef IF_PERF_CNT_EN
        ,
        .issue_count   (issue_count),
        .stall_count   (stall_count)
`endif
    );

    always #5 sysclk = ~sysclk;

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    function automatic logic [12:0] exp_bus(input logic [7:0] word, input logic [3:0] pc);
        return {1'b1, word, pc};
    endfunction

    function automatic logic [12:0] obs_bus();
        return {inst_valid, inst, rs, rt, imm, inst_pc};
    endfunction

    task automatic load_word(input logic [3:0] addr, input logic [7:0] data);
        load_en = 1'b1;
        load_addr = addr;
        load_data = data;
        tick();
        load_en = 1'b0;
        mem_model[addr] = data;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic load_basic();
        load_word(4'd0, 8'h25);
        load_word(4'd1, 8'h5A);
        load_word(4'd2, 8'h9F);
        load_word(4'd3, 8'hE0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({obs_bus(), halted, busy} !== 15'd0) begin
            failures++;
            $display("FAIL reset_state: got bus=%h halted=%b busy=%b, want all zero", obs_bus(), halted, busy);
        end
    endtask

    task automatic test_sequential();
        logic [7:0] words [3];
        words[0] = 8'h25; words[1] = 8'h5A; words[2] = 8'h9F;
        load_basic();
        inst_ready = 1'b1;
        pulse_start();
        checks++;
        if (inst_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL seq_fetch_cycle: got valid=%b busy=%b, want valid=0 busy=1", inst_valid, busy);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs_bus() !== exp_bus(words[i], 4'(i))) begin
                failures++;
                $display("FAIL seq_issue%0d: got %h want %h", i, obs_bus(), exp_bus(words[i], 4'(i)));
            end
        end
        tick();
        checks++;
        if (inst_valid !== 1'b0 || halted !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL seq_halt: got valid=%b halted=%b busy=%b, want 0 1 0", inst_valid, halted, busy);
        end
        tick();
        checks++;
        if (inst_valid !== 1'b0 || halted !== 1'b1) begin
            failures++;
            $display("FAIL seq_halt_hold: got valid=%b halted=%b, want 0 1", inst_valid, halted);
        end
    endtask

    task automatic test_stall();
        inst_ready = 1'b0;
        pulse_start();
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_bus() !== exp_bus(8'h25, 4'd0)) begin
                failures++;
                $display("FAIL stall_hold%0d: got %h want %h", i, obs_bus(), exp_bus(8'h25, 4'd0));
            end
            tick();
        end
        inst_ready = 1'b1;
        checks++;
        if (obs_bus() !== exp_bus(8'h25, 4'd0)) begin
            failures++;
            $display("FAIL stall_release: got %h want %h", obs_bus(), exp_bus(8'h25, 4'd0));
        end
        tick();
        checks++;
        if (obs_bus() !== exp_bus(8'h5A, 4'd1)) begin
            failures++;
            $display("FAIL stall_next: got %h want %h", obs_bus(), exp_bus(8'h5A, 4'd1));
        end
        tick();
        tick();
        checks++;
        if (halted !== 1'b1 || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_end_halt: got halted=%b valid=%b, want 1 0", halted, inst_valid);
        end
    endtask

    task automatic test_branch();
        load_word(4'd3, 8'h31);
        load_word(4'd4, 8'hE0);
        inst_ready = 1'b1;
        pulse_start();
        tick();
        tick();
        checks++;
        if (obs_bus() !== exp_bus(8'h5A, 4'd1)) begin
            failures++;
            $display("FAIL branch_pre: got %h want %h", obs_bus(), exp_bus(8'h5A, 4'd1));
        end
        branch_taken = 1'b1;
        branch_target = 4'd3;
        tick();
        branch_taken = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL branch_flush: got valid=%b busy=%b, want 0 1", inst_valid, busy);
        end
        tick();
        checks++;
        if (obs_bus() !== exp_bus(8'h31, 4'd3)) begin
            failures++;
            $display("FAIL branch_target: got %h want %h", obs_bus(), exp_bus(8'h31, 4'd3));
        end
        tick();
        checks++;
        if (inst_valid !== 1'b0 || halted !== 1'b1) begin
            failures++;
            $display("FAIL branch_halt: got valid=%b halted=%b, want 0 1", inst_valid, halted);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] seq [3];
        seq[0] = 4'd15; seq[1] = 4'd0; seq[2] = 4'd1;
        for (int a = 0; a < 16; a++) load_word(4'(a), 8'h20);
        inst_ready = 1'b1;
        pulse_start();
        branch_taken = 1'b1;
        branch_target = 4'd15;
        tick();
        branch_taken = 1'b0;
        checks++;
        if (inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL wrap_flush: got valid=%b want 0", inst_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs_bus() !== exp_bus(8'h20, seq[i])) begin
                failures++;
                $display("FAIL wrap_seq%0d: got %h want %h", i, obs_bus(), exp_bus(8'h20, seq[i]));
            end
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        load_basic();
        inst_ready = 1'b0;
        pulse_start();
        tick();
        checks++;
        if (inst_valid !== 1'b1) begin
            failures++;
            $display("FAIL rmid_pre: got valid=%b want 1", inst_valid);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({obs_bus(), halted, busy} !== 15'd0) begin
            failures++;
            $display("FAIL rmid_cleared: got bus=%h halted=%b busy=%b, want all zero", obs_bus(), halted, busy);
        end
        inst_ready = 1'b1;
        pulse_start();
        tick();
        checks++;
        if (obs_bus() !== exp_bus(8'h25, 4'd0)) begin
            failures++;
            $display("FAIL rmid_restart0: got %h want %h", obs_bus(), exp_bus(8'h25, 4'd0));
        end
        tick();
        checks++;
        if (obs_bus() !== exp_bus(8'h5A, 4'd1)) begin
            failures++;
            $display("FAIL rmid_restart1: got %h want %h", obs_bus(), exp_bus(8'h5A, 4'd1));
        end
        do_reset();
    endtask

    task automatic test_random();
        logic [3:0]  exp_pc = '0;
        logic        running = 1'b0;
        logic        stalled_prev = 1'b0;
        logic        branch_prev = 1'b0;
        logic [12:0] prev_bus = '0;
        logic        rdy;
        logic        br;
        logic [3:0]  tgt;
        logic [7:0]  w;
        int          n_hs = 0;
        for (int a = 0; a < 16; a++) begin
            w = 8'($urandom);
            if ($urandom_range(0, 5) == 0) w[7:5] = 3'b111;
            load_word(4'(a), w);
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!busy) begin
                checks++;
                if (inst_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd_idle_valid cyc=%0d: got valid=%b want 0", cyc, inst_valid);
                end
                if (halted && running) begin
                    checks++;
                    if (mem_model[exp_pc][7:5] !== 3'b111) begin
                        failures++;
                        $display("FAIL rnd_halt_point cyc=%0d: halted with next pc=%0d word=%h, want HALT opcode", cyc, exp_pc, mem_model[exp_pc]);
                    end
                    running = 1'b0;
                end
                inst_ready = 1'b0;
                if ($urandom_range(0, 2) == 0) begin
                    w = 8'($urandom);
                    if ($urandom_range(0, 5) == 0) w[7:5] = 3'b111;
                    load_word(4'($urandom_range(0, 15)), w);
                end else begin
                    pulse_start();
                    exp_pc = '0;
                    running = 1'b1;
                end
                stalled_prev = 1'b0;
                branch_prev = 1'b0;
                continue;
            end
            if (branch_prev) begin
                checks++;
                if (inst_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd_flush cyc=%0d: got valid=%b want 0", cyc, inst_valid);
                end
            end
            if (inst_valid) begin
                checks++;
                if (obs_bus() !== exp_bus(mem_model[exp_pc], exp_pc) || inst === 3'b111) begin
                    failures++;
                    $display("FAIL rnd_issue cyc=%0d: got %h want %h", cyc, obs_bus(), exp_bus(mem_model[exp_pc], exp_pc));
                end
            end
            if (stalled_prev) begin
                checks++;
                if (obs_bus() !== prev_bus) begin
                    failures++;
                    $display("FAIL rnd_stall_hold cyc=%0d: got %h want %h", cyc, obs_bus(), prev_bus);
                end
            end
            rdy = ($urandom_range(0, 3) != 0);
            br  = ($urandom_range(0, 7) == 0);
            tgt = 4'($urandom_range(0, 15));
            inst_ready = rdy;
            branch_taken = br;
            branch_target = tgt;
            if (inst_valid && rdy) begin
                exp_pc = exp_pc + 4'd1;
                n_hs++;
            end
            if (br) exp_pc = tgt;
            stalled_prev = inst_valid && !rdy && !br;
            prev_bus = obs_bus();
            branch_prev = br;
            tick();
            branch_taken = 1'b0;
        end
        checks++;
        if (n_hs < 50) begin
            failures++;
            $display("FAIL rnd_progress: got %0d handshakes, want at least 50", n_hs);
        end
        inst_ready = 1'b0;
        do_reset();
    endtask

`ifdef IF_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        checks++;
        if (issue_count !== 16'd0 || stall_count !== 16'd0) begin
            failures++;
            $display("FAIL perf_reset: got issue=%0d stall=%0d, want 0 0", issue_count, stall_count);
        end
        load_basic();
        inst_ready = 1'b0;
        pulse_start();
        tick();
        tick();
        tick();
        inst_ready = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (issue_count !== 16'd3 || stall_count !== 16'd2 || halted !== 1'b1) begin
            failures++;
            $display("FAIL perf_counts: got issue=%0d stall=%0d halted=%b, want 3 2 1", issue_count, stall_count, halted);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_wrap();
        test_reset_mid();
        test_random();
`ifdef IF_PERF_CNT_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
